// File: rtl/wave_mode_pkg.sv
// Shared constants and step-direction encoding for the wave mode selector.
package wave_mode_pkg;

  localparam int unsigned DEF_NUM_MODES       = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_RESET_MODE      = 0;
  localparam bit          DEF_WRAP            = 1'b1;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_NEXT = 2'd1,
    DIR_PREV = 2'd2
  } dir_e;

endpackage

// File: rtl/key_debounce.sv
// Raw key conditioning: 2-flop synchroniser, stable-level debounce, and a
// one-cycle registered pulse on each accepted press (0->1 of the debounced level).
module key_debounce
  import wave_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic key_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The level flips on the cycle the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/wave_mode_selector.sv
// Two-key mode selector: debounced next/prev presses step a registered mode
// index with wrap or saturate behaviour, plus one-hot decode and change strobe.
module wave_mode_selector
  import wave_mode_pkg::*;
#(
  parameter int unsigned NUM_MODES       = DEF_NUM_MODES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RESET_MODE      = DEF_RESET_MODE,
  parameter bit          WRAP            = DEF_WRAP
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         next_key,
  input  logic                         prev_key,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic [NUM_MODES-1:0]         mode_onehot,
  output logic                         mode_changed
);

  localparam int unsigned          MODE_W   = $clog2(NUM_MODES);
  localparam logic [MODE_W-1:0]    LAST     = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0]    RST_MODE = MODE_W'(RESET_MODE);
  localparam logic [NUM_MODES-1:0] RST_OH   = NUM_MODES'(1) << RESET_MODE;

  logic                 next_press;
  logic                 prev_press;
  dir_e                 dir;
  logic [MODE_W-1:0]    mode_q;
  logic [MODE_W-1:0]    mode_d;
  logic [NUM_MODES-1:0] onehot_q;
  logic [NUM_MODES-1:0] onehot_d;
  logic                 changed_q;
  logic                 changed_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next_db (
    .clk    (clk),
    .n_rst  (n_rst),
    .key_i  (next_key),
    .press_o(next_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_prev_db (
    .clk    (clk),
    .n_rst  (n_rst),
    .key_i  (prev_key),
    .press_o(prev_press)
  );

  // Simultaneous presses cancel out.
  always_comb begin
    dir = DIR_NONE;
    case ({next_press, prev_press})
      2'b10:   dir = DIR_NEXT;
      2'b01:   dir = DIR_PREV;
      default: dir = DIR_NONE;
    endcase
  end

  // Ends of the range either wrap or hold; the strobe follows any real change.
  always_comb begin
    mode_d = mode_q;
    case (dir)
      DIR_NEXT: begin
        if (mode_q == LAST) begin
          if (WRAP) mode_d = '0;
        end else begin
          mode_d = mode_q + MODE_W'(1);
        end
      end
      DIR_PREV: begin
        if (mode_q == '0) begin
          if (WRAP) mode_d = LAST;
        end else begin
          mode_d = mode_q - MODE_W'(1);
        end
      end
      default: mode_d = mode_q;
    endcase
    changed_d = (mode_d != mode_q);
    onehot_d  = NUM_MODES'(1) << mode_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q    <= RST_MODE;
      onehot_q  <= RST_OH;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      onehot_q  <= onehot_d;
      changed_q <= changed_d;
    end
  end

  assign mode         = mode_q;
  assign mode_onehot  = onehot_q;
  assign mode_changed = changed_q;

endmodule

// File: tb/tb_wave_mode_selector.sv
// Directed and random checks of wave_mode_selector in three parameterisations
// sharing key stimulus: defaults, 5 saturating modes, and reset mode 2.
module tb_wave_mode_selector;

  logic clk = 1'b0;
  logic n_rst;
  logic rst_rm_n;
  logic next_key;
  logic prev_key;

  logic [1:0] mode_def;
  logic [3:0] oh_def;
  logic       mc_def;
  logic [2:0] mode_sat;
  logic [4:0] oh_sat;
  logic       mc_sat;
  logic [1:0] mode_rm;
  logic [3:0] oh_rm;
  logic       mc_rm;

  int checks   = 0;
  int failures = 0;
  int strb_def = 0;
  int strb_sat = 0;
  int strb_rm  = 0;

  always #5 clk = ~clk;

  wave_mode_selector u_def (
    .clk         (clk),
    .n_rst       (n_rst),
    .next_key    (next_key),
    .prev_key    (prev_key),
    .mode        (mode_def),
    .mode_onehot (oh_def),
    .mode_changed(mc_def)
  );

  wave_mode_selector #(
    .NUM_MODES(5),
    .WRAP     (1'b0)
  ) u_sat (
    .clk         (clk),
    .n_rst       (n_rst),
    .next_key    (next_key),
    .prev_key    (prev_key),
    .mode        (mode_sat),
    .mode_onehot (oh_sat),
    .mode_changed(mc_sat)
  );

  wave_mode_selector #(
    .RESET_MODE(2)
  ) u_rm (
    .clk         (clk),
    .n_rst       (rst_rm_n),
    .next_key    (next_key),
    .prev_key    (prev_key),
    .mode        (mode_rm),
    .mode_onehot (oh_rm),
    .mode_changed(mc_rm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling outputs on the falling edge and tallying strobes.
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (mc_def) strb_def++;
      if (mc_sat) strb_sat++;
      if (mc_rm)  strb_rm++;
    end
  endtask

  task automatic do_reset();
    n_rst    = 1'b0;
    rst_rm_n = 1'b0;
    next_key = 1'b0;
    prev_key = 1'b0;
    cycles(3);
    n_rst    = 1'b1;
    rst_rm_n = 1'b1;
    cycles(2);
    strb_def = 0;
    strb_sat = 0;
    strb_rm  = 0;
  endtask

  task automatic press(input bit nxt);
    if (nxt) next_key = 1'b1;
    else     prev_key = 1'b1;
    cycles(12);
    next_key = 1'b0;
    prev_key = 1'b0;
    cycles(10);
  endtask

  int exp_next[4]  = '{1, 2, 3, 0};
  int exp_prev[3]  = '{3, 2, 1};
  int exp_sat[6]   = '{1, 2, 3, 4, 4, 4};
  int exp_sstrb[6] = '{1, 2, 3, 4, 4, 4};

  initial begin
    logic [1:0] pm_def;
    logic [2:0] pm_sat;
    logic [1:0] pm_rm;
    int hold_n;
    int hold_p;

    // Reset state
    n_rst    = 1'b0;
    rst_rm_n = 1'b0;
    next_key = 1'b0;
    prev_key = 1'b0;
    cycles(2);
    check("rst_mode_def", 32'(mode_def), 32'd0);
    check("rst_oh_def",   32'(oh_def),   32'b0001);
    check("rst_mc_def",   32'(mc_def),   32'd0);
    check("rst_mode_sat", 32'(mode_sat), 32'd0);
    check("rst_oh_sat",   32'(oh_sat),   32'b00001);
    check("rst_mode_rm",  32'(mode_rm),  32'd2);
    check("rst_oh_rm",    32'(oh_rm),    32'b0100);

    // Latency: held key steps on edge 7 with a one-cycle strobe
    do_reset();
    next_key = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      check($sformatf("lat_mode_e%0d", k), 32'(mode_def), (k >= 7) ? 32'd1 : 32'd0);
      check($sformatf("lat_mc_e%0d", k),   32'(mc_def),   (k == 7) ? 32'd1 : 32'd0);
      if (k == 7) check("lat_onehot", 32'(oh_def), 32'b0010);
    end
    next_key = 1'b0;
    cycles(10);
    check("lat_one_strobe", 32'(strb_def), 32'd1);

    // Forward wrap then backward wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b1);
      check($sformatf("next_mode_%0d", i), 32'(mode_def), 32'(exp_next[i]));
      check($sformatf("next_strb_%0d", i), 32'(strb_def), 32'(i + 1));
    end
    check("wrap_oh", 32'(oh_def), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      press(1'b0);
      check($sformatf("prev_mode_%0d", i), 32'(mode_def), 32'(exp_prev[i]));
      check($sformatf("prev_strb_%0d", i), 32'(strb_def), 32'(i + 5));
    end

    // Saturation with 5 modes
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press(1'b1);
      check($sformatf("sat_mode_%0d", i), 32'(mode_sat), 32'(exp_sat[i]));
      check($sformatf("sat_strb_%0d", i), 32'(strb_sat), 32'(exp_sstrb[i]));
    end
    check("sat_oh_top", 32'(oh_sat), 32'b10000);
    do_reset();
    press(1'b0);
    check("sat_prev0_mode", 32'(mode_sat), 32'd0);
    check("sat_prev0_strb", 32'(strb_sat), 32'd0);
    check("sat_prev0_oh",   32'(oh_sat),   32'b00001);

    // Short glitch and simultaneous keys
    do_reset();
    next_key = 1'b1;
    cycles(2);
    next_key = 1'b0;
    cycles(12);
    check("glitch_mode", 32'(mode_def), 32'd0);
    check("glitch_strb", 32'(strb_def), 32'd0);
    next_key = 1'b1;
    prev_key = 1'b1;
    cycles(20);
    check("both_mode",     32'(mode_def), 32'd0);
    check("both_strb",     32'(strb_def), 32'd0);
    check("both_mode_sat", 32'(mode_sat), 32'd0);
    next_key = 1'b0;
    prev_key = 1'b0;
    cycles(12);
    check("both_rel_strb", 32'(strb_def), 32'd0);

    // Reset mid-debounce discards the partial press
    do_reset();
    next_key = 1'b1;
    cycles(3);
    rst_rm_n = 1'b0;
    next_key = 1'b0;
    cycles(2);
    check("midrst_mode_in", 32'(mode_rm), 32'd2);
    check("midrst_mc_in",   32'(mc_rm),   32'd0);
    rst_rm_n = 1'b1;
    cycles(20);
    check("midrst_mode", 32'(mode_rm), 32'd2);
    check("midrst_oh",   32'(oh_rm),   32'b0100);
    check("midrst_strb", 32'(strb_rm), 32'd0);

    // Random key traffic with output invariants
    do_reset();
    pm_def = mode_def;
    pm_sat = mode_sat;
    pm_rm  = mode_rm;
    hold_n = 0;
    hold_p = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold_n == 0) begin
        next_key = 1'($urandom_range(0, 1));
        hold_n   = int'($urandom_range(1, 10));
      end
      if (hold_p == 0) begin
        prev_key = 1'($urandom_range(0, 1));
        hold_p   = int'($urandom_range(1, 10));
      end
      hold_n--;
      hold_p--;
      cycles(1);
      check("rnd_range_def", 32'(mode_def < 2'd3 || mode_def == 2'd3), 32'd1);
      check("rnd_range_sat", 32'(mode_sat < 3'd5), 32'd1);
      check("rnd_oh_def",    32'(oh_def), 32'(4'b0001 << mode_def));
      check("rnd_oh_sat",    32'(oh_sat), 32'(5'b00001 << mode_sat));
      check("rnd_oh_rm",     32'(oh_rm),  32'(4'b0001 << mode_rm));
      check("rnd_mc_def",    32'(mc_def), 32'(mode_def != pm_def));
      check("rnd_mc_sat",    32'(mc_sat), 32'(mode_sat != pm_sat));
      check("rnd_mc_rm",     32'(mc_rm),  32'(mode_rm != pm_rm));
      pm_def = mode_def;
      pm_sat = mode_sat;
      pm_rm  = mode_rm;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
